// File: rtl/uart_core_cfg_if.sv
// Host-side FIFO handshakes, runtime frame config and serial pins of uart_core_cfg.
interface uart_core_cfg_if #(
  parameter int FIFO_EXP = 4,
  parameter int DIV_BITS = 16
);
  logic [DIV_BITS-1:0] cfg_div;
  logic [1:0]          cfg_dbits;
  logic [1:0]          cfg_parity;
  logic                cfg_stop2;
  logic                rx;
  logic                tx;
  logic                tx_wr;
  logic [7:0]          tx_data;
  logic                tx_full;
  logic [FIFO_EXP:0]   tx_level;
  logic                tx_busy;
  logic                rx_rd;
  logic [7:0]          rx_data;
  logic                rx_perr;
  logic                rx_ferr;
  logic                rx_empty;
  logic [FIFO_EXP:0]   rx_level;
  logic                err_overrun;
  logic                err_clr;

  modport slave (
    input  cfg_div, cfg_dbits, cfg_parity, cfg_stop2, rx, tx_wr, tx_data, rx_rd, err_clr,
    output tx, tx_full, tx_level, tx_busy, rx_data, rx_perr, rx_ferr, rx_empty, rx_level,
           err_overrun
  );

  modport master (
    output cfg_div, cfg_dbits, cfg_parity, cfg_stop2, rx, tx_wr, tx_data, rx_rd, err_clr,
    input  tx, tx_full, tx_level, tx_busy, rx_data, rx_perr, rx_ferr, rx_empty, rx_level,
           err_overrun
  );
endinterface

// File: rtl/uart_core_cfg.sv
// Runtime-configurable UART: baud tick generator, 16x oversampled Rx/Tx FSMs, FWFT FIFOs.
// state | meaning: IDLE line idle | START start bit | DATA data bits | PARITY parity bit
//       | STOP stop bit(s) | WAIT_HI (Rx) framing error, wait for line high
module uart_core_cfg_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_ni,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);
  logic [W-1:0]  r_mem [2**AW];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_do_wr, w_do_rd;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (AW+1)'(2**AW));
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];
  assign o_level = r_cnt;

  always_ff @(posedge clk) if (w_do_wr) r_mem[r_wptr] <= i_wdata;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

module uart_core_cfg #(
  parameter int FIFO_EXP = 4,
  parameter int DIV_BITS = 16
) (
  input logic            clk,
  input logic            rst_ni,
  uart_core_cfg_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI} state_t;

  logic [DIV_BITS-1:0] r_baud_cnt;
  logic                w_tick;

  assign w_tick = (r_baud_cnt >= bus.cfg_div);

  always_ff @(posedge clk) begin
    if (!rst_ni)     r_baud_cnt <= '0;
    else if (w_tick) r_baud_cnt <= '0;
    else             r_baud_cnt <= r_baud_cnt + 1'b1;
  end

  logic [7:0]      w_tx_head, w_tx_mask, w_tx_word;
  logic            w_tx_empty, w_tx_full, w_tx_pop, w_tx_frame_end, w_tx_bit;
  logic [FIFO_EXP:0] w_tx_level;
  state_t          r_tx_state;
  logic [3:0]      r_tx_cnt;
  logic [2:0]      r_tx_idx, r_tx_last;
  logic [7:0]      r_tx_word;
  logic            r_tx_par_en, r_tx_par_bit, r_tx_stop2, r_tx_stop_idx, r_tx, r_tx_busy;

  uart_core_cfg_fifo #(.W(8), .AW(FIFO_EXP)) u_tx_fifo (
    .clk(clk), .rst_ni(rst_ni), .i_wr(bus.tx_wr), .i_rd(w_tx_pop), .i_wdata(bus.tx_data),
    .o_rdata(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_level(w_tx_level)
  );

  assign w_tx_mask      = 8'hFF >> (2'd3 - bus.cfg_dbits);
  assign w_tx_word      = w_tx_head & w_tx_mask;
  assign w_tx_frame_end = (r_tx_state == S_STOP) && w_tick && (r_tx_cnt == 4'd15) &&
                          (!r_tx_stop2 || r_tx_stop_idx);
  assign w_tx_pop       = !w_tx_empty && ((r_tx_state == S_IDLE) || w_tx_frame_end);

  always_comb begin
    w_tx_bit = 1'b1;
    case (r_tx_state)
      S_START:  w_tx_bit = 1'b0;
      S_DATA:   w_tx_bit = r_tx_word[r_tx_idx];
      S_PARITY: w_tx_bit = r_tx_par_bit;
      default:  w_tx_bit = 1'b1;
    endcase
  end

  // Line value of each bit is driven on its first tick, so a new frame's start edge lands on a tick.
  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_tx_state    <= S_IDLE;
      r_tx_cnt      <= '0;
      r_tx_idx      <= '0;
      r_tx_last     <= '0;
      r_tx_word     <= '0;
      r_tx_par_en   <= 1'b0;
      r_tx_par_bit  <= 1'b0;
      r_tx_stop2    <= 1'b0;
      r_tx_stop_idx <= 1'b0;
      r_tx          <= 1'b1;
      r_tx_busy     <= 1'b0;
    end else begin
      if (r_tx_state != S_IDLE && w_tick) begin
        r_tx_cnt <= r_tx_cnt + 4'd1;
        if (r_tx_cnt == 4'd0) r_tx <= w_tx_bit;
        if (r_tx_cnt == 4'd15) begin
          case (r_tx_state)
            S_START: begin
              r_tx_state <= S_DATA;
              r_tx_idx   <= '0;
            end
            S_DATA: begin
              if (r_tx_idx == r_tx_last) begin
                r_tx_state    <= r_tx_par_en ? S_PARITY : S_STOP;
                r_tx_stop_idx <= 1'b0;
              end else begin
                r_tx_idx <= r_tx_idx + 3'd1;
              end
            end
            S_PARITY: begin
              r_tx_state    <= S_STOP;
              r_tx_stop_idx <= 1'b0;
            end
            S_STOP: begin
              if (r_tx_stop2 && !r_tx_stop_idx) begin
                r_tx_stop_idx <= 1'b1;
              end else begin
                r_tx_state <= S_IDLE;
                r_tx_busy  <= 1'b0;
              end
            end
            default: ;
          endcase
        end
      end
      if (w_tx_pop) begin
        r_tx_state   <= S_START;
        r_tx_cnt     <= '0;
        r_tx_word    <= w_tx_word;
        r_tx_last    <= 3'd4 + {1'b0, bus.cfg_dbits};
        r_tx_par_en  <= ^bus.cfg_parity;
        r_tx_par_bit <= (^w_tx_word) ^ bus.cfg_parity[1];
        r_tx_stop2   <= bus.cfg_stop2;
        r_tx_busy    <= 1'b1;
      end
    end
  end

  logic            r_rx_s1, r_rx_s2, w_rx, w_rx_full, w_rx_empty, w_overrun, w_rx_perr;
  logic [9:0]      w_rx_head, r_rx_word;
  logic [FIFO_EXP:0] w_rx_level;
  state_t          r_rx_state;
  logic [3:0]      r_rx_cnt;
  logic [2:0]      r_rx_idx, r_rx_last;
  logic [7:0]      r_rx_shift;
  logic            r_rx_par_en, r_rx_par_odd, r_rx_par, r_rx_push, r_overrun;

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= bus.rx;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_rx      = r_rx_s2;
  assign w_rx_perr = r_rx_par_en & ((^r_rx_shift) ^ r_rx_par ^ r_rx_par_odd);

  always_ff @(posedge clk) begin
    if (!rst_ni) begin
      r_rx_state   <= S_IDLE;
      r_rx_cnt     <= '0;
      r_rx_idx     <= '0;
      r_rx_last    <= '0;
      r_rx_shift   <= '0;
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_par     <= 1'b0;
      r_rx_push    <= 1'b0;
      r_rx_word    <= '0;
    end else begin
      r_rx_push <= 1'b0;
      case (r_rx_state)
        S_IDLE: if (!w_rx) begin
          r_rx_state   <= S_START;
          r_rx_cnt     <= '0;
          r_rx_shift   <= '0;
          r_rx_last    <= 3'd4 + {1'b0, bus.cfg_dbits};
          r_rx_par_en  <= ^bus.cfg_parity;
          r_rx_par_odd <= bus.cfg_parity[1];
        end
        S_START: if (w_tick) begin
          if (r_rx_cnt == 4'd7) begin
            r_rx_state <= w_rx ? S_IDLE : S_DATA;
            r_rx_cnt   <= '0;
            r_rx_idx   <= '0;
          end else begin
            r_rx_cnt <= r_rx_cnt + 4'd1;
          end
        end
        S_DATA: if (w_tick) begin
          r_rx_cnt <= r_rx_cnt + 4'd1;
          if (r_rx_cnt == 4'd15) begin
            r_rx_shift[r_rx_idx] <= w_rx;
            if (r_rx_idx == r_rx_last) r_rx_state <= r_rx_par_en ? S_PARITY : S_STOP;
            else                       r_rx_idx   <= r_rx_idx + 3'd1;
          end
        end
        S_PARITY: if (w_tick) begin
          r_rx_cnt <= r_rx_cnt + 4'd1;
          if (r_rx_cnt == 4'd15) begin
            r_rx_par   <= w_rx;
            r_rx_state <= S_STOP;
          end
        end
        S_STOP: if (w_tick) begin
          r_rx_cnt <= r_rx_cnt + 4'd1;
          if (r_rx_cnt == 4'd15) begin
            r_rx_push  <= 1'b1;
            r_rx_word  <= {~w_rx, w_rx_perr, r_rx_shift};
            r_rx_state <= w_rx ? S_IDLE : S_WAIT_HI;
          end
        end
        S_WAIT_HI: if (w_rx) r_rx_state <= S_IDLE;
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  uart_core_cfg_fifo #(.W(10), .AW(FIFO_EXP)) u_rx_fifo (
    .clk(clk), .rst_ni(rst_ni), .i_wr(r_rx_push), .i_rd(bus.rx_rd), .i_wdata(r_rx_word),
    .o_rdata(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_level(w_rx_level)
  );

  // A simultaneous pop frees the slot, so only an unserved push into a full FIFO is an overrun.
  assign w_overrun = r_rx_push && w_rx_full && !bus.rx_rd;

  always_ff @(posedge clk) begin
    if (!rst_ni)          r_overrun <= 1'b0;
    else if (w_overrun)   r_overrun <= 1'b1;
    else if (bus.err_clr) r_overrun <= 1'b0;
  end

  assign bus.tx          = r_tx;
  assign bus.tx_busy     = r_tx_busy;
  assign bus.tx_full     = w_tx_full;
  assign bus.tx_level    = w_tx_level;
  assign bus.rx_data     = w_rx_head[7:0];
  assign bus.rx_perr     = w_rx_head[8];
  assign bus.rx_ferr     = w_rx_head[9];
  assign bus.rx_empty    = w_rx_empty;
  assign bus.rx_level    = w_rx_level;
  assign bus.err_overrun = r_overrun;
endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench for uart_core_cfg: Tx framing/timing, loopback, Rx error flags, overrun, reset.
module tb_uart_core_cfg;
  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic rx_drv = 1'b1;
  logic loop_en = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  uart_core_cfg_if #(.FIFO_EXP(4), .DIV_BITS(16)) bus ();

  uart_core_cfg #(.FIFO_EXP(4), .DIV_BITS(16)) dut (
    .clk(clk), .rst_ni(rst_ni), .bus(bus.slave)
  );

  assign bus.rx = loop_en ? bus.tx : rx_drv;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n, input int bt);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      cyc(bt);
    end
  endtask

  task automatic pop;
    bus.rx_rd = 1'b1;
    cyc(1);
    bus.rx_rd = 1'b0;
  endtask

  logic        smp_tx [200];
  logic [10:0] exp_7e2;
  logic [7:0]  words [3];
  int          nb, fall1, rise1, fall2;
  logic        prev;

  initial begin
    bus.cfg_div = '0; bus.cfg_dbits = 2'b11; bus.cfg_parity = 2'b00; bus.cfg_stop2 = 1'b0;
    bus.tx_wr = 1'b0; bus.tx_data = '0; bus.rx_rd = 1'b0; bus.err_clr = 1'b0;
    cyc(3);
    check_eq("rst_tx", bus.tx, 1);
    check_eq("rst_busy", bus.tx_busy, 0);
    check_eq("rst_tx_full", bus.tx_full, 0);
    check_eq("rst_tx_level", bus.tx_level, 0);
    check_eq("rst_rx_empty", bus.rx_empty, 1);
    check_eq("rst_rx_level", bus.rx_level, 0);
    check_eq("rst_rx_data", bus.rx_data, 0);
    check_eq("rst_rx_perr", bus.rx_perr, 0);
    check_eq("rst_rx_ferr", bus.rx_ferr, 0);
    check_eq("rst_overrun", bus.err_overrun, 0);
    rst_ni = 1'b1;
    cyc(2);

    // 7E2, cfg_div=0: 0x41
    bus.cfg_div = 16'd0; bus.cfg_dbits = 2'b10; bus.cfg_parity = 2'b01; bus.cfg_stop2 = 1'b1;
    bus.tx_data = 8'h41; bus.tx_wr = 1'b1;
    cyc(1);
    bus.tx_wr = 1'b0;
    check_eq("busy_early", bus.tx_busy, 0);
    cyc(1);
    check_eq("busy_latency", bus.tx_busy, 1);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      smp_tx[i] = bus.tx;
      if (bus.tx_busy) nb++;
      cyc(1);
    end
    exp_7e2 = 11'b110_1000_0010;
    check_eq("tx_before_tick", smp_tx[0], 1);
    for (int k = 0; k < 11; k++)
      check_eq($sformatf("tx_7e2_bit%0d", k), smp_tx[8 + 16 * k], exp_7e2[k]);
    check_eq("start_last", smp_tx[16], 0);
    check_eq("data0_first", smp_tx[17], 1);
    check_eq("busy_cycles", nb, 176);

    // Loopback 8N1, cfg_div=3
    bus.cfg_div = 16'd3; bus.cfg_dbits = 2'b11; bus.cfg_parity = 2'b00; bus.cfg_stop2 = 1'b0;
    loop_en = 1'b1;
    words[0] = 8'h55; words[1] = 8'hA3; words[2] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      bus.tx_data = words[k]; bus.tx_wr = 1'b1;
      cyc(1);
    end
    bus.tx_wr = 1'b0;
    fall1 = -1; rise1 = -1; fall2 = -1; prev = 1'b1;
    for (int i = 0; i < 2100; i++) begin
      if (prev && !bus.tx) begin
        if (fall1 < 0) fall1 = i;
        else if (fall2 < 0 && i >= fall1 + 600) fall2 = i;
      end
      if (!prev && bus.tx && fall1 >= 0 && rise1 < 0) rise1 = i;
      prev = bus.tx;
      cyc(1);
    end
    check_eq("start_low_len", rise1 - fall1, 64);
    check_eq("frame_period", fall2 - fall1, 640);
    for (int w = 0; w < 500 && bus.rx_level != 5'd3; w++) cyc(1);
    check_eq("loop_level", bus.rx_level, 3);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("loop_data%0d", k), bus.rx_data, words[k]);
      check_eq($sformatf("loop_perr%0d", k), bus.rx_perr, 0);
      check_eq($sformatf("loop_ferr%0d", k), bus.rx_ferr, 0);
      pop();
    end
    check_eq("loop_empty", bus.rx_empty, 1);
    loop_en = 1'b0;
    cyc(10);

    // 8O1 0x0F with wrong parity bit (0 instead of 1)
    bus.cfg_parity = 2'b10;
    send_bits(16'h041E, 11, 64);
    cyc(20);
    check_eq("perr_empty", bus.rx_empty, 0);
    check_eq("perr_data", bus.rx_data, 8'h0F);
    check_eq("perr_flag", bus.rx_perr, 1);
    check_eq("perr_ferr", bus.rx_ferr, 0);
    pop();

    // 8N1 0xA5 with stop=0, line low for three bit times
    bus.cfg_parity = 2'b00;
    send_bits(16'h014A, 9, 64);
    rx_drv = 1'b0;
    cyc(192);
    check_eq("ferr_level_low", bus.rx_level, 1);
    rx_drv = 1'b1;
    cyc(200);
    check_eq("ferr_level_hi", bus.rx_level, 1);
    check_eq("ferr_data", bus.rx_data, 8'hA5);
    check_eq("ferr_flag", bus.rx_ferr, 1);
    check_eq("ferr_perr", bus.rx_perr, 0);
    pop();
    check_eq("ferr_empty", bus.rx_empty, 1);

    // glitch of 4 ticks
    rx_drv = 1'b0;
    cyc(16);
    rx_drv = 1'b1;
    cyc(200);
    check_eq("glitch_level", bus.rx_level, 0);

    // 17 frames with no reads, cfg_div=0
    bus.cfg_div = 16'd0;
    cyc(5);
    for (int i = 0; i < 17; i++) begin
      send_bits({6'b0, 1'b1, 8'h30 + 8'(i), 1'b0}, 10, 16);
      cyc(16);
      if (i == 15) begin
        check_eq("ovr_level16", bus.rx_level, 16);
        check_eq("ovr_not_yet", bus.err_overrun, 0);
        check_eq("ovr_full_tx", bus.tx_full, 0);
      end
    end
    check_eq("ovr_level", bus.rx_level, 16);
    check_eq("ovr_flag", bus.err_overrun, 1);
    for (int k = 0; k < 16; k++) begin
      check_eq($sformatf("ovr_data%0d", k), bus.rx_data, 8'h30 + 8'(k));
      pop();
    end
    check_eq("ovr_sticky", bus.err_overrun, 1);
    check_eq("ovr_drained", bus.rx_empty, 1);
    bus.err_clr = 1'b1;
    cyc(1);
    bus.err_clr = 1'b0;
    check_eq("ovr_cleared", bus.err_overrun, 0);

    // reset during Tx data bit 3
    bus.cfg_dbits = 2'b11; bus.cfg_parity = 2'b00; bus.cfg_stop2 = 1'b0;
    bus.tx_data = 8'h00; bus.tx_wr = 1'b1;
    cyc(2);
    bus.tx_wr = 1'b0;
    cyc(70);
    check_eq("mid_tx_low", bus.tx, 0);
    check_eq("mid_busy", bus.tx_busy, 1);
    check_eq("mid_level", bus.tx_level, 1);
    rst_ni = 1'b0;
    cyc(1);
    check_eq("rst_mid_tx", bus.tx, 1);
    check_eq("rst_mid_busy", bus.tx_busy, 0);
    check_eq("rst_mid_level", bus.tx_level, 0);
    rst_ni = 1'b1;
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_core_cfg.md
# uart_core_cfg

Runtime-configurable UART core with integrated baud generator, receiver, transmitter and Rx/Tx FIFOs. It is the successor to the fixed-format 8N1 core. Baud divisor, word length (5–8), parity (none/even/odd) and stop bits (1/2) are runtime inputs. It adds per-word parity/framing status, a sticky overrun flag, FIFO fill levels and a Tx busy indication. It sits between the SHA host logic (byte-wide FIFO handshakes) and the board serial pins.

## Interface
- FIFO_EXP, 4: FIFO depth = 2^FIFO_EXP entries, applies to both FIFOs.
- DIV_BITS, 16: width of the baud divisor input.
- Oversampling is fixed at 16 ticks per bit; data path width is fixed at 8.

- clk  in  1  single clock for the whole block.
- rst_ni  in  1  reset; synchronous, active-low.
- cfg_div  in  DIV_BITS  tick period = cfg_div+1 clk cycles.
- cfg_dbits  in  2  word length: 00=5, 01=6, 10=7, 11=8.
- cfg_parity  in  2  parity: 00 none, 01 even, 10 odd, 11 treated as none.
- cfg_stop2  in  1  1 = two stop bits on Tx.
- rx  in  1  serial input, asynchronous.
- tx  out  1  serial output.
- tx_wr  in  1  push tx_data into Tx FIFO.
- tx_data  in  8  Tx word; bits above the word length are ignored.
- tx_full  out  1  Tx FIFO full.
- tx_level  out  FIFO_EXP+1  Tx FIFO occupancy.
- tx_busy  out  1  frame in progress on tx.
- rx_rd  in  1  pop Rx FIFO head.
- rx_data  out  8  Rx head word, zero-extended above the word length.
- rx_perr  out  1  parity error flag of the head word.
- rx_ferr  out  1  framing error flag of the head word.
- rx_empty  out  1  Rx FIFO empty.
- rx_level  out  FIFO_EXP+1  Rx FIFO occupancy.
- err_overrun  out  1  sticky; set when a word is dropped because the Rx FIFO is full.
- err_clr  in  1  clears err_overrun.

## Operation
- **Baud generator**
  - The counter runs 0..cfg_div; tick is high for one cycle when count >= cfg_div, then count returns to 0.
  - A cfg_div decrease below the current count gives a tick on the next cycle.
  - cfg_div=0 gives a tick every cycle.
- **FIFOs**
  - First-word-fall-through: the head is visible combinationally while not empty.
  - Write when full is dropped. Read when empty is ignored.
  - Read and write together on a full FIFO: both take effect and the level is unchanged.
  - Read and write together on an empty FIFO: the write is accepted and the read is ignored.
  - Rx entries are 10 bits: {ferr, perr, data}.
  - rx_data, rx_perr and rx_ferr are forced to 0 while rx_empty=1.
- **Tx state machine (IDLE, START, DATA, PARITY, STOP)**
  - IDLE with FIFO not empty: pop the head, latch word, cfg_dbits, cfg_parity and cfg_stop2, and go to START. tx_busy=1 from this cycle.
  - Each bit lasts 16 ticks.
  - Frame order: START (0), DATA LSB first for N bits, PARITY if enabled, then 1 or 2 stop bits (1).
  - Even parity makes the count of ones over data+parity even; odd parity makes it odd.
  - After the last stop tick: pop the next word if available (back-to-back frames), else go to IDLE with tx_busy=0.
- **Rx state machine (IDLE, START, DATA, PARITY, STOP, WAIT_HI)**
  - rx passes through a 2-flop synchronizer that resets to 1.
  - IDLE: synced rx=0 goes to START and latches the config.
  - START: at tick 7, if rx is still 0, reset the tick count and go to DATA. Otherwise treat it as a glitch and return to IDLE.
  - DATA and PARITY: sample at every 16th tick (mid-bit).
  - STOP: sample the first stop bit only, at mid-bit, then push {ferr = (stop==0), perr = parity mismatch, data}.
  - If the stop bit was 1, go to IDLE. If it was 0, go to WAIT_HI until synced rx=1.
  - A push while the FIFO is full is dropped and sets err_overrun. A push together with rx_rd on a full FIFO is not an overrun.
  - err_clr together with a new overrun leaves err_overrun set.
- Config changes mid-frame have no effect until the next frame.

## Timing
- Bit time = 16*(cfg_div+1) clk cycles.
- Tx latency: tx_wr into an empty idle core gives tx_busy high 2 cycles later. The tx falling edge follows on the next tick after that.
- Rx latency: the FIFO push occurs 1 cycle after the stop-bit mid-sample tick, and rx_empty falls on the following cycle. Synchronizer delay is 2 cycles.
- Reset values: tx=1, tx_busy=0, tx_full=0, tx_level=0, rx_empty=1, rx_level=0, rx_data=0, rx_perr=0, rx_ferr=0, err_overrun=0.
- All state returns to IDLE, FIFOs are emptied and the baud count is set to 0.
- Reset asserted mid-frame: tx=1 on the cycle after the reset edge. The partial Rx word is discarded.

## Test plan
- Loopback tx→rx, cfg_div=3, 8N1; write 0x55, 0xA3, 0x00 → the same three words are read in order with perr=ferr=0. Each start bit is low for 64 cycles and each frame lasts 640 cycles.
- 7E2, cfg_div=0; write 0x41 → tx shows 0, 1000001, parity 0, then 1, 1, each bit 16 cycles. tx_busy is high for 176 cycles.
- Rx driven with 8O1 0x0F and the parity bit inverted → head data=0x0F, rx_perr=1, rx_ferr=0.
- Rx frame with stop=0 and the line held low 3 bit times → one entry with rx_ferr=1 and no further entries until rx returns high.
- FIFO_EXP=4: 17 frames received with no reads → rx_level=16, err_overrun=1, first 16 words intact. err_clr → err_overrun=0.
- rx pulse low for 4 ticks → no entry. rst_ni low during Tx data bit 3 → tx=1, tx_busy=0, tx_level=0 on the next cycle.
